add_share_ctrl: RTL and testbench

Round-robin controller that shares one registered 12-bit adder among N requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, sequences the adder through load and execute cycles, and returns the sum with the winner's ID on a single shared response channel. It sits between the requesting engines and the adder datapath, which is implemented inside this block.

---
 rtl/add_share_pkg.sv | 19 +
 rtl/add_rr_pick.sv | 37 +++
 rtl/add_share_ctrl.sv | 135 +++++++++++++
 tb/tb_add_share_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_share_pkg.sv
// Shared definitions for the add_share_ctrl block: FSM state encoding,
// default geometry and the completed-operation counter width.
package add_share_pkg;

  // Default number of requesters and operand width.
  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 12;

  // Width of the wrapping completed-response counter.
  localparam int OPS_W = 16;

  // Controller states: wait for a request, run the adder, hold the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/add_rr_pick.sv
// Combinational round-robin picker. The search starts one position after
// the previous winner and wraps, so every active requester is served in
// turn and inactive ones are skipped without costing a cycle.
module add_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]  last_grant_i,
  output logic [N_REQ-1:0] grant_oh_o,
  output logic [ID_W-1:0]  grant_idx_o,
  output logic             any_valid_o
);

  int   idx;
  logic found;

  // Walk the requesters in priority order; the first active one wins.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_i) + k) % N_REQ;
      if (!found && req_valid_i[idx]) begin
        found            = 1'b1;
        grant_oh_o[idx]  = 1'b1;
        grant_idx_o      = ID_W'(idx);
      end
    end
  end

  // A grant exists exactly when some requester is active.
  assign any_valid_o = |req_valid_i;

endmodule

// File: rtl/add_share_ctrl.sv
// Round-robin controller sharing one registered adder among N_REQ
// requesters. Sequence per operation: IDLE (grant + latch operands),
// LOAD (adder enabled, sum registered), RESP (hold response until taken).
// Optional build macro ADD_SHARE_CARRY_EN adds the rsp_cout output, the
// carry out of a+b registered alongside rsp_sum.
module add_share_ctrl
  import add_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
`ifdef ADD_SHARE_CARRY_EN
  output logic                   rsp_cout,
`endif
  output logic                   busy,
  output logic [OPS_W-1:0]       ops_done
);

  state_e           state_q;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [OPS_W-1:0] ops_q;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  logic [N_REQ-1:0] grant_oh;
  logic [ID_W-1:0]  grant_idx;
  logic             any_valid;

  // Unpack the flat operand buses into per-requester lanes.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  add_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .grant_oh_o   (grant_oh),
    .grant_idx_o  (grant_idx),
    .any_valid_o  (any_valid)
  );

  // Adder datapath: operates on the latched operands, result captured in LOAD.
`ifdef ADD_SHARE_CARRY_EN
  logic [WIDTH:0] add_full;
  logic           cout_d;
  logic           cout_q;
  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sum_d    = add_full[WIDTH-1:0];
  assign cout_d   = add_full[WIDTH];
`else
  assign sum_d    = a_q + b_q;
`endif

  // Controller FSM with its datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      rsp_id_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      ops_q        <= '0;
`ifdef ADD_SHARE_CARRY_EN
      cout_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            a_q          <= a_arr[grant_idx];
            b_q          <= b_arr[grant_idx];
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          // Adder enabled: the response fields change only here, on entry to RESP.
          sum_q    <= sum_d;
          rsp_id_q <= id_q;
`ifdef ADD_SHARE_CARRY_EN
          cout_q   <= cout_d;
`endif
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            ops_q   <= ops_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant strobe is only offered in IDLE and is suppressed while in reset.
  assign req_ready = (rst_n && (state_q == IDLE)) ? grant_oh : '0;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = sum_q;
  assign ops_done  = ops_q;
`ifdef ADD_SHARE_CARRY_EN
  assign rsp_cout  = cout_q;
`endif

endmodule

// File: tb/tb_add_share_ctrl.sv
// Self-checking bench for add_share_ctrl: a requester model feeds operands,
// expected responses go into a scoreboard queue at grant time and are
// compared when the DUT presents them.
module tb_add_share_ctrl;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           busy;
  logic [15:0]    ops_done;
`ifdef ADD_SHARE_CARRY_EN
  logic           rsp_cout;
`endif

  add_share_ctrl #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
`ifdef ADD_SHARE_CARRY_EN
    .rsp_cout  (rsp_cout),
`endif
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  sum;
    logic          cout;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          credits[N];
  logic [W-1:0] opa[N];
  logic [W-1:0] opb[N];
  int          m_state;
  int          m_last;
  logic [15:0] m_ops;
  bit          rand_ops;
  bit          rand_bp;
  logic [W-1:0] last_sum;
  logic [IW-1:0] last_id;
  logic        last_cout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pick();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (credits[idx] > 0) return idx;
    end
    return -1;
  endfunction

  function automatic int glog(input int k);
    if (k < grant_log.size()) return grant_log[k];
    return -1;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = (credits[i] > 0);
      req_a[i*W +: W]   = opa[i];
      req_b[i*W +: W]   = opb[i];
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last  = N - 1;
    m_ops   = '0;
    sb.delete();
  endtask

  // One clock: compare at the falling edge, update stimulus just after the rising edge.
  task automatic step();
    int         g;
    int         acc;
    logic [N-1:0] exp_rdy;
    logic [W:0] full;
    exp_t       e;
    @(negedge clk);
    acc     = -1;
    g       = m_pick();
    exp_rdy = '0;
    check_eq("ops_done", 32'(ops_done), 32'(m_ops));
    check_eq("busy", 32'(busy), 32'(m_state != 0));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
    case (m_state)
      0: begin
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready_idle", 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
          acc    = g;
          full   = {1'b0, opa[g]} + {1'b0, opb[g]};
          e.id   = IW'(g);
          e.sum  = full[W-1:0];
          e.cout = full[W];
          sb.push_back(e);
          grant_log.push_back(g);
          m_last  = g;
          m_state = 1;
        end
      end
      1: begin
        check_eq("req_ready_load", 32'(req_ready), 32'd0);
        m_state = 2;
      end
      default: begin
        check_eq("req_ready_resp", 32'(req_ready), 32'd0);
        if (sb.size() == 0) begin
          check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          check_eq("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          check_eq("rsp_sum", 32'(rsp_sum), 32'(sb[0].sum));
`ifdef ADD_SHARE_CARRY_EN
          check_eq("rsp_cout", 32'(rsp_cout), 32'(sb[0].cout));
`endif
          if (rsp_ready) begin
            last_sum  = rsp_sum;
            last_id   = rsp_id;
            last_cout = sb[0].cout;
            void'(sb.pop_front());
            m_ops   = m_ops + 16'd1;
            m_state = 0;
          end
        end
      end
    endcase
    @(posedge clk);
    #1;
    if (acc >= 0) begin
      credits[acc]--;
      if (rand_ops) begin
        opa[acc] = W'($urandom);
        opb[acc] = W'($urandom);
      end
    end
    if (rand_bp) rsp_ready = 1'($urandom_range(0, 1));
    apply_inputs();
  endtask

  task automatic drain(input int max, output int cycles);
    bit pending;
    cycles = 0;
    forever begin
      pending = 1'b0;
      for (int i = 0; i < N; i++) if (credits[i] > 0) pending = 1'b1;
      if (!(pending || m_state != 0) || cycles >= max) break;
      step();
      cycles++;
    end
    check_eq("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic reset_check(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check_eq({tag, "_rsp_sum"}, 32'(rsp_sum), 32'd0);
    check_eq({tag, "_ops_done"}, 32'(ops_done), 32'd0);
`ifdef ADD_SHARE_CARRY_EN
    check_eq({tag, "_rsp_cout"}, 32'(rsp_cout), 32'd0);
`endif
  endtask

  initial begin
    int cyc;
    int guard;
    int base;
    rand_ops  = 1'b0;
    rand_bp   = 1'b0;
    last_sum  = '0;
    last_id   = '0;
    last_cout = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      credits[i] = 0;
      opa[i]     = '0;
      opb[i]     = '0;
    end
    apply_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_check("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request from requester 2.
    opa[2] = 12'h123; opb[2] = 12'h456; credits[2] = 1;
    apply_inputs();
    drain(50, cyc);
    check_eq("single_cycles", 32'(cyc), 32'd3);
    check_eq("single_id", 32'(last_id), 32'd2);
    check_eq("single_sum", 32'(last_sum), 32'h579);
    check_eq("single_ops", 32'(ops_done), 32'd1);
    $display("txn single: id=%0d sum=0x%0h ops_done=%0d", last_id, last_sum, ops_done);

    // Wrap-around through requester 3 (leaves last_grant at 3).
    opa[3] = 12'hFFF; opb[3] = 12'h001; credits[3] = 1;
    apply_inputs();
    drain(50, cyc);
    check_eq("wrap_sum", 32'(last_sum), 32'h000);
`ifdef ADD_SHARE_CARRY_EN
    check_eq("wrap_cout", 32'(rsp_cout), 32'd1);
`endif
    $display("txn wrap: id=%0d sum=0x%0h", last_id, last_sum);

    // Fairness: all four requesters active, one response every 3 cycles.
    rand_ops = 1'b1;
    for (int i = 0; i < N; i++) begin
      credits[i] = 2; opa[i] = W'($urandom); opb[i] = W'($urandom);
    end
    apply_inputs();
    grant_log.delete();
    base = int'(ops_done);
    repeat (18) step();
    check_eq("fair_ops", 32'(ops_done), 32'(base + 6));
    for (int k = 0; k < 6; k++) check_eq("fair_order", 32'(glog(k)), 32'(k % N));
    $display("txn fairness: ops_done=%0d grants=%0d", ops_done, grant_log.size());
    drain(100, cyc);

    // Backpressure: hold the response 10 cycles with others pending.
    rsp_ready  = 1'b0;
    credits[1] = 1;
    apply_inputs();
    grant_log.delete();
    repeat (2) step();
    credits[0] = 1; credits[2] = 1;
    apply_inputs();
    repeat (10) step();
    check_eq("bp_stall_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    drain(100, cyc);
    check_eq("bp_grant0", 32'(glog(0)), 32'd1);
    check_eq("bp_grant1", 32'(glog(1)), 32'd2);
    check_eq("bp_grant2", 32'(glog(2)), 32'd0);
    $display("txn backpressure: grants %0d,%0d,%0d", glog(0), glog(1), glog(2));

    // Reset while in LOAD.
    credits[2] = 1;
    apply_inputs();
    guard = 0;
    while (m_state != 1 && guard < 8) begin
      step();
      guard++;
    end
    check_eq("load_reached", 32'(busy), 32'd1);
    credits[3] = 1;
    apply_inputs();
    rst_n = 1'b0;
    #1;
    reset_check("rst_load");
    @(negedge clk);
    reset_check("rst_hold");
    @(posedge clk);
    #1;
    model_reset();
    credits[0] = 1;
    apply_inputs();
    grant_log.delete();
    rst_n = 1'b1;
    drain(100, cyc);
    check_eq("post_rst_first", 32'(glog(0)), 32'd0);
    check_eq("post_rst_second", 32'(glog(1)), 32'd3);
    check_eq("post_rst_ops", 32'(ops_done), 32'd2);
    $display("txn reset-in-load: first grant %0d, ops_done=%0d", glog(0), ops_done);

    // Sparse requesters 1 and 3, no idle cycles between grants.
    credits[1] = 2; credits[3] = 2;
    apply_inputs();
    grant_log.delete();
    drain(100, cyc);
    check_eq("sparse_cycles", 32'(cyc), 32'd12);
    check_eq("sparse_g0", 32'(glog(0)), 32'd1);
    check_eq("sparse_g1", 32'(glog(1)), 32'd3);
    check_eq("sparse_g2", 32'(glog(2)), 32'd1);
    check_eq("sparse_g3", 32'(glog(3)), 32'd3);
    $display("txn sparse: %0d cycles for 4 ops", cyc);

    // Random traffic with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < N; i++) begin
      credits[i] = $urandom_range(0, 10);
      opa[i] = W'($urandom); opb[i] = W'($urandom);
    end
    apply_inputs();
    drain(3000, cyc);
    rand_bp   = 1'b0;
    rsp_ready = 1'b1;
    drain(50, cyc);
    check_eq("rand_sb_empty", 32'(sb.size()), 32'd0);
    $display("txn random: ops_done=%0d", ops_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
